// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg: operation codes shared by the universal register and its bench
package univ_reg_pkg;
    typedef enum logic [2:0] {
        M_HOLD, M_LOAD, M_SHL, M_SHR, M_ROTL, M_ROTR, M_INC, M_DEC
    } mode_t;
endpackage

// File: rtl/univ_reg_next.sv
// univ_reg_next: next-state and terminal-count logic for the universal register
module univ_reg_next
    import univ_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q_next,
    output logic             tc
);
    // unknown modes fall to the default arm and hold
    always_comb begin
        q_next = q;
        case (mode)
            M_LOAD:  q_next = d;
            M_SHL:   q_next = {q[WIDTH-2:0], sir};
            M_SHR:   q_next = {sil, q[WIDTH-1:1]};
            M_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
            M_INC:   q_next = q + 1'b1;
            M_DEC:   q_next = q - 1'b1;
            default: q_next = q;
        endcase
    end

    assign tc = (mode == M_INC && q == '1) || (mode == M_DEC && q == '0);
endmodule

// File: rtl/univ_reg.sv
// univ_reg: edge-triggered multi-mode register (load/shift/rotate/count)
module univ_reg
    import univ_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIL,
    input  logic             SIR,
    output logic [WIDTH-1:0] Q,
    output logic             SOL,
    output logic             SOR,
    output logic             TC
);
    logic [WIDTH-1:0] q_next;

    univ_reg_next #(.WIDTH(WIDTH)) u_next (
        .q(Q), .mode(MODE), .d(D), .sil(SIL), .sir(SIR), .q_next(q_next), .tc(TC)
    );

    always_ff @(posedge CLK or negedge R) begin
        if (!R)
            Q <= RESET_VAL;
        else if (EN)
            Q <= q_next;
    end

    assign SOL = Q[WIDTH-1];
    assign SOR = Q[0];
endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed vector table plus reset/wrap/width sequences for univ_reg
module tb_univ_reg;
    import univ_reg_pkg::*;

    typedef struct {
        logic       en;
        mode_t      mode;
        logic [7:0] d;
        logic       sil;
        logic       sir;
        logic [7:0] q;
        logic       tc;
        logic       sol;
        logic       sor;
    } vec_t;

    logic        CLK = 1'b0;
    logic        R, EN, SIL, SIR;
    logic [2:0]  MODE;
    logic [7:0]  d8, q8;
    logic [1:0]  d2, q2;
    logic [15:0] d16, q16;
    logic        sol8, sor8, tc8, sol2, sor2, tc2, sol16, sor16, tc16;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        vecs[$];

    always #5 CLK = ~CLK;

    univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .CLK(CLK), .R(R), .EN(EN), .MODE(MODE), .D(d8), .SIL(SIL), .SIR(SIR),
        .Q(q8), .SOL(sol8), .SOR(sor8), .TC(tc8)
    );
    univ_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
        .CLK(CLK), .R(R), .EN(EN), .MODE(MODE), .D(d2), .SIL(SIL), .SIR(SIR),
        .Q(q2), .SOL(sol2), .SOR(sor2), .TC(tc2)
    );
    univ_reg #(.WIDTH(16), .RESET_VAL(16'hBEEF)) dut16 (
        .CLK(CLK), .R(R), .EN(EN), .MODE(MODE), .D(d16), .SIL(SIL), .SIR(SIR),
        .Q(q16), .SOL(sol16), .SOR(sor16), .TC(tc16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //               en    mode    d      sil   sir   q      tc    sol   sor
        vecs.push_back('{1'b1, M_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, M_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b0, M_LOAD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_HOLD, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_SHL,  8'h00, 1'b0, 1'b1, 8'h4B, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, M_SHR,  8'h00, 1'b0, 1'b0, 8'h25, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, M_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_ROTL, 8'h00, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, M_ROTR, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_ROTR, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, M_SHR,  8'h00, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, M_SHL,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, M_LOAD, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, M_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_DEC,  8'h00, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, M_INC,  8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

        R = 1'b0; EN = 1'b1; MODE = M_LOAD; SIL = 1'b0; SIR = 1'b0;
        d8 = 8'hFF; d2 = 2'b11; d16 = 16'h1234;
        #1;
        chk("rst_async_q8", {24'd0, q8}, 32'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_hold_q8", {24'd0, q8}, 32'h00);
            chk("rst_tc8", {31'd0, tc8}, 32'd0);
        end
        chk("rst_q16", {16'd0, q16}, 32'hBEEF);
        chk("rst_q2", {30'd0, q2}, 32'd0);

        @(negedge CLK) R = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            EN = vecs[i].en; MODE = vecs[i].mode; d8 = vecs[i].d;
            SIL = vecs[i].sil; SIR = vecs[i].sir;
            tick();
            chk($sformatf("vec%0d_q", i), {24'd0, q8}, {24'd0, vecs[i].q});
            chk($sformatf("vec%0d_tc", i), {31'd0, tc8}, {31'd0, vecs[i].tc});
            chk($sformatf("vec%0d_sol", i), {31'd0, sol8}, {31'd0, vecs[i].sol});
            chk($sformatf("vec%0d_sor", i), {31'd0, sor8}, {31'd0, vecs[i].sor});
        end

        // count down from zero: TC is visible before the wrapping edge
        @(negedge CLK) MODE = M_DEC; EN = 1'b1;
        #1;
        chk("dec_wrap_tc_pre", {31'd0, tc8}, 32'd1);
        tick();
        chk("dec_wrap_q", {24'd0, q8}, 32'hFF);
        chk("dec_wrap_tc_post", {31'd0, tc8}, 32'd0);

        @(negedge CLK) MODE = M_LOAD; d8 = 8'h5A;
        tick();
        chk("pre_rst_q8", {24'd0, q8}, 32'h5A);
        #2 R = 1'b0;
        #1;
        chk("mid_rst_q8", {24'd0, q8}, 32'h00);
        chk("mid_rst_q16", {16'd0, q16}, 32'hBEEF);
        chk("mid_rst_q2", {30'd0, q2}, 32'd0);

        @(negedge CLK) R = 1'b1; MODE = M_LOAD; d16 = 16'hFFFF; d2 = 2'b11;
        tick();
        chk("w16_load", {16'd0, q16}, 32'hFFFF);
        chk("w2_load", {30'd0, q2}, 32'd3);
        @(negedge CLK) MODE = M_INC;
        #1;
        chk("w16_tc_pre", {31'd0, tc16}, 32'd1);
        chk("w2_tc_pre", {31'd0, tc2}, 32'd1);
        tick();
        chk("w16_inc_wrap", {16'd0, q16}, 32'h0000);
        chk("w2_inc_wrap", {30'd0, q2}, 32'd0);
        chk("w16_tc_post", {31'd0, tc16}, 32'd0);
        @(negedge CLK) MODE = M_DEC;
        #1;
        chk("w2_dec_tc_pre", {31'd0, tc2}, 32'd1);
        tick();
        chk("w2_dec_wrap", {30'd0, q2}, 32'd3);
        @(negedge CLK) MODE = M_SHL; SIR = 1'b0;
        tick();
        chk("w2_shl", {30'd0, q2}, 32'd2);
        chk("w2_sol", {31'd0, sol2}, 32'd1);
        chk("w2_sor", {31'd0, sor2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
